// File: rtl/sample_burst_writer.sv
// sample_burst_writer: packs a 16-bit sample stream into 128-bit words, buffers
// them in a small FIFO and writes them to DDR2 through the MIG native app port.
// Every word is a single BL8 write: one command beat and one data beat, and the
// two may be accepted in either order. A full FIFO drops the word and sets the
// sticky overflow flag, so capture never stalls.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start with calibration complete
// S_CAPTURE| packing samples, pushing packed words into the FIFO
// S_DRAIN  | run length reached, emptying the FIFO into the MIG
// S_DONE   | run finished, waiting for the next start

module sample_burst_writer #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int ADDR_WIDTH    = 27,
  parameter int FIFO_DEPTH    = 4,
  parameter int CAPTURE_WORDS = 1024,
  localparam int DATA_WIDTH   = 8 * SAMPLE_WIDTH,
  localparam int MASK_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_calib_complete,
  input  logic                    start,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [ADDR_WIDTH-3:0]   words_written,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [MASK_WIDTH-1:0]   app_wdf_mask,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int PUSH_W = $clog2(CAPTURE_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 state;
  logic [2:0]             lane;
  logic [DATA_WIDTH-1:0]  pack_buf;
  logic [PUSH_W-1:0]      pushed;

  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;

  // in_flight covers a word from issue until both its beats are accepted;
  // cmd_acc / dat_acc remember a beat that was accepted ahead of the other.
  logic                   in_flight;
  logic                   cmd_acc;
  logic                   dat_acc;

  logic                   start_ok;
  logic                   push;
  logic                   push_ok;
  logic                   pop;
  logic                   issue;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   cmd_ok;
  logic                   dat_ok;
  logic [DATA_WIDTH-1:0]  push_word;

  assign app_cmd      = 3'b000;
  assign app_wdf_mask = '0;
  assign app_wdf_end  = app_wdf_wren;

  // Handshake decode shared by the FSM and the write engine.
  always_comb begin
    start_ok   = start && init_calib_complete && (state == S_IDLE || state == S_DONE);
    push       = (state == S_CAPTURE) && sample_valid && (lane == 3'd7);
    push_word  = {sample_data, pack_buf[DATA_WIDTH-SAMPLE_WIDTH-1:0]};
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    cmd_ok     = cmd_acc || (app_en && app_rdy);
    dat_ok     = dat_acc || (app_wdf_wren && app_wdf_rdy);
    pop        = in_flight && cmd_ok && dat_ok;
    // A pop in the same cycle frees the slot the push needs.
    push_ok    = push && (!fifo_full || pop);
    issue      = !in_flight && !fifo_empty && init_calib_complete;
  end

  // Run sequencing, sample packing and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      lane     <= 3'd0;
      pack_buf <= '0;
      pushed   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state    <= S_CAPTURE;
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            lane     <= 3'd0;
            pushed   <= '0;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            pack_buf[int'(lane)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sample_data;
            lane <= lane + 3'd1;
            if (lane == 3'd7) begin
              // Dropped words still count toward the run length.
              pushed <= pushed + PUSH_W'(1);
              if (!push_ok) overflow <= 1'b1;
              if (pushed == PUSH_W'(CAPTURE_WORDS - 1)) state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_empty && !in_flight) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, MIG write strobes, address and accepted-word count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      in_flight     <= 1'b0;
      cmd_acc       <= 1'b0;
      dat_acc       <= 1'b0;
      app_en        <= 1'b0;
      app_wdf_wren  <= 1'b0;
      app_wdf_data  <= '0;
      app_addr      <= '0;
      words_written <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push_ok) - CNT_W'(pop);

      if (start_ok) begin
        app_addr      <= '0;
        words_written <= '0;
      end else if (pop) begin
        app_addr      <= app_addr + ADDR_WIDTH'(8);
        words_written <= words_written + (ADDR_WIDTH-2)'(1);
      end

      if (pop) begin
        // One idle cycle between words keeps the strobe edges simple.
        in_flight    <= 1'b0;
        cmd_acc      <= 1'b0;
        dat_acc      <= 1'b0;
        app_en       <= 1'b0;
        app_wdf_wren <= 1'b0;
      end else if (in_flight) begin
        if (app_en && app_rdy) begin
          app_en  <= 1'b0;
          cmd_acc <= 1'b1;
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          app_wdf_wren <= 1'b0;
          dat_acc      <= 1'b1;
        end
      end else if (issue) begin
        in_flight    <= 1'b1;
        app_en       <= 1'b1;
        app_wdf_wren <= 1'b1;
        app_wdf_data <= fifo_mem[rd_ptr];
      end
    end
  end

endmodule
